// File: rtl/gelato_types.sv
// -----------------------------------------------------------------------------
// gelato_types
//   Shared types for the execute write-back path.
//   - reg_num_t      : architectural register index within a warp
//   - warp_num_t     : warp index
//   - thread_mask_t  : one bit per lane, set lanes are written
//   - warp_reg_t     : one full warp register, NUM_LANES lanes of LANE_W bits
//   - wb_req_t       : a complete write-back payload as held in the output
//                      register of the register-file write port
//   - NUM_WB_SRC     : number of execute units feeding write-back
// -----------------------------------------------------------------------------
package gelato_types;

    localparam int NUM_WB_SRC = 4;
    localparam int NUM_LANES  = 32;
    localparam int LANE_W     = 32;
    localparam int REG_NUM_W  = 6;
    localparam int WARP_NUM_W = 5;

    typedef logic [REG_NUM_W-1:0]               reg_num_t;
    typedef logic [WARP_NUM_W-1:0]              warp_num_t;
    typedef logic [NUM_LANES-1:0]               thread_mask_t;
    typedef logic [NUM_LANES-1:0][LANE_W-1:0]   warp_reg_t;

    typedef struct packed {
        warp_num_t    warp_num;
        reg_num_t     reg_num;
        thread_mask_t thread_mask;
        warp_reg_t    data;
    } wb_req_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// -----------------------------------------------------------------------------
// gelato_rr_arbiter
//   Round-robin arbiter with an explicit advance strobe. The pointer names the
//   highest-priority requester; the scan runs upward from the pointer and
//   wraps from N-1 to 0. The pointer moves to one past the granted index only
//   when advance is asserted, so the owner decides when a grant "counts".
//
//   Ports
//     clk        clock
//     rst_n      asynchronous active-low reset (pointer -> 0)
//     req        per-requester request
//     advance    commit the current grant: pointer <= grant_idx + 1 (mod N)
//     grant      one-hot grant, all zero when nothing requests
//     grant_idx  binary index of the granted requester
// -----------------------------------------------------------------------------
module gelato_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan N candidates starting at the pointer; the extra sum bit lets the
    // wrap work for non-power-of-two N as well.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gelato_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gelato_rf_wb_arbiter
//   Register-file side of execute write-back. NUM_SRC execute units hold a
//   request (valid + payload) until they see their src_caught pulse. One
//   request per cycle is picked round-robin and parked in a single-entry
//   output register that drives the register-file write port. The scoreboard
//   is told which warp/register retired in the same cycle the register file
//   accepts the write.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     src_valid         per-source request valid, held until caught
//     src_caught        per-source one-cycle accept pulse (combinational)
//     src_reg_num       per-source destination register
//     src_warp_num      per-source destination warp
//     src_thread_mask   per-source lane write mask
//     src_data          per-source per-lane result data
//     rf_wr_en          register-file write request (output register full)
//     rf_wr_ready       register file takes the write this cycle
//     rf_reg_num / rf_warp_num / rf_thread_mask / rf_data   write payload
//     sb_release        scoreboard release pulse (write accepted)
//     sb_warp_num / sb_reg_num                              released target
// -----------------------------------------------------------------------------
module gelato_rf_wb_arbiter
    import gelato_types::*;
#(
    parameter int NUM_SRC = NUM_WB_SRC,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_caught,
    input  reg_num_t     [NUM_SRC-1:0]  src_reg_num,
    input  warp_num_t    [NUM_SRC-1:0]  src_warp_num,
    input  thread_mask_t [NUM_SRC-1:0]  src_thread_mask,
    input  warp_reg_t    [NUM_SRC-1:0]  src_data,
    output logic                        rf_wr_en,
    input  logic                        rf_wr_ready,
    output reg_num_t                    rf_reg_num,
    output warp_num_t                   rf_warp_num,
    output thread_mask_t                rf_thread_mask,
    output warp_reg_t                   rf_data,
    output logic                        sb_release,
    output warp_num_t                   sb_warp_num,
    output reg_num_t                    sb_reg_num
);

    logic               wr_en_q;
    wb_req_t            out_q;
    logic               out_free;
    logic [NUM_SRC-1:0] arb_req;
    logic [NUM_SRC-1:0] arb_grant;
    logic [SRC_W-1:0]   arb_grant_idx;
    logic               advance;

    // The output register can take a new payload when empty or when its
    // current write is being accepted this very cycle (back-to-back writes).
    assign out_free = !wr_en_q || rf_wr_ready;

    // rst_n gates the request so no source is told it was caught while the
    // block is held in reset; that accept would otherwise be lost.
    assign arb_req  = src_valid & {NUM_SRC{out_free && rst_n}};
    assign advance  = |arb_grant;

    gelato_rr_arbiter #(
        .N     (NUM_SRC),
        .IDX_W (SRC_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .advance   (advance),
        .grant     (arb_grant),
        .grant_idx (arb_grant_idx)
    );

    assign src_caught = arb_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            out_q   <= '0;
        end else if (out_free) begin
            wr_en_q <= advance;
            if (advance) begin
                out_q.warp_num    <= src_warp_num[arb_grant_idx];
                out_q.reg_num     <= src_reg_num[arb_grant_idx];
                out_q.thread_mask <= src_thread_mask[arb_grant_idx];
                out_q.data        <= src_data[arb_grant_idx];
            end
        end
    end

    assign rf_wr_en       = wr_en_q;
    assign rf_reg_num     = out_q.reg_num;
    assign rf_warp_num    = out_q.warp_num;
    assign rf_thread_mask = out_q.thread_mask;
    assign rf_data        = out_q.data;

    // A zero lane mask is still a write as far as the scoreboard is concerned.
    assign sb_release  = wr_en_q && rf_wr_ready;
    assign sb_warp_num = out_q.warp_num;
    assign sb_reg_num  = out_q.reg_num;

endmodule
